// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared constants and types for the pipeline flow controller.
// Flow codes mirror the rooth_defines.v encoding; the legacy macros are
// provided here as well so older code keeps compiling.
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
`ifndef FLOW_WIDTH
`define FLOW_WIDTH   2
`define FLOW_WORK    2'd0
`define FLOW_STOP    2'd1
`define FLOW_REFRESH 2'd2
`endif

`ifndef PIPE_STAGE_PC
`define PIPE_STAGE_PC  0
`define PIPE_STAGE_IF  1
`define PIPE_STAGE_ID  2
`define PIPE_STAGE_EX  3
`define PIPE_STAGE_WB  4
`endif

package pipe_flow_ctrl_pkg;

    localparam int unsigned FLOW_W = 2;

    localparam logic [FLOW_W-1:0] FLOW_WORK    = 2'd0;
    localparam logic [FLOW_W-1:0] FLOW_STOP    = 2'd1;
    localparam logic [FLOW_W-1:0] FLOW_REFRESH = 2'd2;

    localparam int unsigned PIPE_STAGE_PC = 0;
    localparam int unsigned PIPE_STAGE_IF = 1;
    localparam int unsigned PIPE_STAGE_ID = 2;
    localparam int unsigned PIPE_STAGE_EX = 3;
    localparam int unsigned PIPE_STAGE_WB = 4;

    // Stop: stall stages below depth, flush the stage at depth.
    // Refresh: flush stages 1..depth, keep stage 0 running.
    typedef enum logic {
        MaskStop,
        MaskRefresh
    } mask_mode_e;

endpackage

// File: rtl/flow_mask_gen.sv
// Combinational per-stage flow code generator for one depth/mode pair.
module flow_mask_gen
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int unsigned STAGES  = 5,
    parameter int unsigned DEPTH_W = 3
) (
    input  logic [DEPTH_W-1:0]       i_depth,
    input  mask_mode_e               i_mode,
    output logic [STAGES*FLOW_W-1:0] o_flow
);

    int unsigned w_d;

    // Build the flow vector stage by stage from depth and mode
    always_comb begin
        o_flow = '0;
        w_d    = 32'(i_depth);
        for (int unsigned s = 0; s < STAGES; s++) begin
            if (i_mode == MaskStop) begin
                if (s < w_d) begin
                    o_flow[s*FLOW_W +: FLOW_W] = FLOW_STOP;
                end else if (s == w_d) begin
                    o_flow[s*FLOW_W +: FLOW_W] = FLOW_REFRESH;
                end else begin
                    o_flow[s*FLOW_W +: FLOW_W] = FLOW_WORK;
                end
            end else begin
                if (s >= 1 && s <= w_d) begin
                    o_flow[s*FLOW_W +: FLOW_W] = FLOW_REFRESH;
                end else begin
                    o_flow[s*FLOW_W +: FLOW_W] = FLOW_WORK;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Registered pipeline flow controller: prioritised holds, redirects with a
// pending-redirect register, hold watchdog. Perf counters exist only when
// PIPE_CTRL_PERF_EN is defined.
module pipe_flow_ctrl
    import pipe_flow_ctrl_pkg::*;
#(
    parameter int unsigned STAGES    = 5,
    parameter int unsigned HOLD_SRCS = 8,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DEPTH_W   = 3,
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [HOLD_SRCS-1:0]         hold_req_i,
    input  logic [HOLD_SRCS*DEPTH_W-1:0] hold_depth_i,
    input  logic                         redir_req_i,
    input  logic                         redir_prio_i,
    input  logic [ADDR_W-1:0]            redir_pc_i,
    input  logic [DEPTH_W-1:0]           redir_depth_i,
    output logic [ADDR_W-1:0]            next_pc_o,
    output logic                         next_pc_vld_o,
    output logic [STAGES*FLOW_W-1:0]     flow_o,
    output logic                         hold_timeout_o,
    output logic [31:0]                  perf_hold_cnt_o,
    output logic [31:0]                  perf_redir_cnt_o
);

    localparam int unsigned        WDT_W        = $clog2(WDT_LIMIT + 1);
    localparam logic [DEPTH_W-1:0] LP_STAGES    = DEPTH_W'(STAGES);
    localparam logic [DEPTH_W-1:0] LP_LAST      = DEPTH_W'(STAGES - 1);
    localparam logic [WDT_W-1:0]   LP_WDT_LIMIT = WDT_W'(WDT_LIMIT);

    logic                     r_pend_vld;
    logic [ADDR_W-1:0]        r_pend_pc;
    logic [DEPTH_W-1:0]       r_pend_depth;
    logic [WDT_W-1:0]         r_wdt_cnt;
    logic                     r_hold_timeout;

    logic                     w_hold_any;
    logic                     w_prio;
    logic                     w_case_hold;
    logic                     w_case_pend;
    logic                     w_case_redir;
    logic                     w_apply;
    logic [DEPTH_W-1:0]       w_hold_depth_raw;
    logic [DEPTH_W-1:0]       w_hold_depth;
    logic [DEPTH_W-1:0]       w_redir_depth_sat;
    logic [DEPTH_W-1:0]       w_apply_depth;
    logic [ADDR_W-1:0]        w_apply_pc;
    logic [STAGES*FLOW_W-1:0] w_flow_hold;
    logic [STAGES*FLOW_W-1:0] w_flow_redir;

    assign w_hold_any   = |hold_req_i;
    assign w_prio       = redir_req_i & redir_prio_i;
    assign w_case_hold  = w_hold_any & ~w_prio;
    assign w_case_pend  = ~w_prio & ~w_hold_any & r_pend_vld;
    assign w_case_redir = ~w_prio & ~w_hold_any & ~r_pend_vld & redir_req_i;
    assign w_apply      = w_prio | w_case_pend | w_case_redir;

    // Pick the lowest-index active hold source and clamp its depth to STAGES
    always_comb begin
        w_hold_depth_raw = '0;
        for (int k = HOLD_SRCS - 1; k >= 0; k--) begin
            if (hold_req_i[k]) begin
                w_hold_depth_raw = hold_depth_i[k*DEPTH_W +: DEPTH_W];
            end
        end
        w_hold_depth = (w_hold_depth_raw > LP_STAGES) ? LP_STAGES : w_hold_depth_raw;
    end

    // Normalise the live redirect depth to 1..STAGES-1
    always_comb begin
        w_redir_depth_sat = redir_depth_i;
        if (redir_depth_i == '0) begin
            w_redir_depth_sat = DEPTH_W'(1);
        end else if (redir_depth_i > LP_LAST) begin
            w_redir_depth_sat = LP_LAST;
        end
    end

    // Select which redirect is being applied this cycle
    always_comb begin
        w_apply_depth = w_redir_depth_sat;
        w_apply_pc    = redir_pc_i;
        if (w_prio) begin
            w_apply_depth = LP_LAST;
        end else if (r_pend_vld) begin
            w_apply_depth = r_pend_depth;
            w_apply_pc    = r_pend_pc;
        end
    end

    flow_mask_gen #(
        .STAGES  (STAGES),
        .DEPTH_W (DEPTH_W)
    ) u_hold_mask (
        .i_depth (w_hold_depth),
        .i_mode  (MaskStop),
        .o_flow  (w_flow_hold)
    );

    flow_mask_gen #(
        .STAGES  (STAGES),
        .DEPTH_W (DEPTH_W)
    ) u_redir_mask (
        .i_depth (w_apply_depth),
        .i_mode  (MaskRefresh),
        .o_flow  (w_flow_redir)
    );

    // Output mux: reset flush, then redirect, then hold, else all stages run
    always_comb begin
        flow_o        = {STAGES{FLOW_WORK}};
        next_pc_vld_o = 1'b0;
        next_pc_o     = '0;
        if (rst) begin
            flow_o = {STAGES{FLOW_REFRESH}};
        end else if (w_apply) begin
            flow_o        = w_flow_redir;
            next_pc_vld_o = 1'b1;
            next_pc_o     = w_apply_pc;
        end else if (w_case_hold) begin
            flow_o = w_flow_hold;
        end
    end

    // Pending redirect: first capture under hold wins, cleared once applied
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_vld   <= 1'b0;
            r_pend_pc    <= '0;
            r_pend_depth <= '0;
        end else if (w_prio || w_case_pend) begin
            r_pend_vld <= 1'b0;
        end else if (w_case_hold && redir_req_i && !r_pend_vld) begin
            r_pend_vld   <= 1'b1;
            r_pend_pc    <= redir_pc_i;
            r_pend_depth <= w_redir_depth_sat;
        end
    end

    // Hold watchdog: saturating count of consecutive held cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt      <= '0;
            r_hold_timeout <= 1'b0;
        end else begin
            if (w_prio || !w_hold_any) begin
                r_wdt_cnt <= '0;
            end else if (r_wdt_cnt != LP_WDT_LIMIT) begin
                r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            end
            r_hold_timeout <= w_hold_any && !w_prio && (r_wdt_cnt == LP_WDT_LIMIT);
        end
    end

    assign hold_timeout_o = r_hold_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_hold_cnt;
    logic [31:0] r_perf_redir_cnt;

    // Wrapping counts of held cycles and applied redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_hold_cnt  <= '0;
            r_perf_redir_cnt <= '0;
        end else begin
            if (w_case_hold) begin
                r_perf_hold_cnt <= r_perf_hold_cnt + 32'd1;
            end
            if (w_apply) begin
                r_perf_redir_cnt <= r_perf_redir_cnt + 32'd1;
            end
        end
    end

    assign perf_hold_cnt_o  = r_perf_hold_cnt;
    assign perf_redir_cnt_o = r_perf_redir_cnt;
`else
    assign perf_hold_cnt_o  = '0;
    assign perf_redir_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl (STAGES=5, WDT_LIMIT=4).
module tb_pipe_flow_ctrl;
    import pipe_flow_ctrl_pkg::*;

    localparam int unsigned STAGES    = 5;
    localparam int unsigned HOLD_SRCS = 8;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DEPTH_W   = 3;
    localparam int unsigned WDT_LIMIT = 4;

    localparam logic [1:0] W = 2'd0;
    localparam logic [1:0] S = 2'd1;
    localparam logic [1:0] R = 2'd2;

    logic                         clk;
    logic                         rst;
    logic [HOLD_SRCS-1:0]         hold_req_i;
    logic [HOLD_SRCS*DEPTH_W-1:0] hold_depth_i;
    logic                         redir_req_i;
    logic                         redir_prio_i;
    logic [ADDR_W-1:0]            redir_pc_i;
    logic [DEPTH_W-1:0]           redir_depth_i;
    logic [ADDR_W-1:0]            next_pc_o;
    logic                         next_pc_vld_o;
    logic [STAGES*FLOW_W-1:0]     flow_o;
    logic                         hold_timeout_o;
    logic [31:0]                  perf_hold_cnt_o;
    logic [31:0]                  perf_redir_cnt_o;

    int total = 0;
    int bad   = 0;

    pipe_flow_ctrl #(
        .STAGES    (STAGES),
        .HOLD_SRCS (HOLD_SRCS),
        .ADDR_W    (ADDR_W),
        .DEPTH_W   (DEPTH_W),
        .WDT_LIMIT (WDT_LIMIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .hold_req_i       (hold_req_i),
        .hold_depth_i     (hold_depth_i),
        .redir_req_i      (redir_req_i),
        .redir_prio_i     (redir_prio_i),
        .redir_pc_i       (redir_pc_i),
        .redir_depth_i    (redir_depth_i),
        .next_pc_o        (next_pc_o),
        .next_pc_vld_o    (next_pc_vld_o),
        .flow_o           (flow_o),
        .hold_timeout_o   (hold_timeout_o),
        .perf_hold_cnt_o  (perf_hold_cnt_o),
        .perf_redir_cnt_o (perf_redir_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage 0 is the first argument
    function automatic logic [9:0] fl(input logic [1:0] s0, input logic [1:0] s1,
                                      input logic [1:0] s2, input logic [1:0] s3,
                                      input logic [1:0] s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hold_req_i    = '0;
        hold_depth_i  = '0;
        redir_req_i   = 1'b0;
        redir_prio_i  = 1'b0;
        redir_pc_i    = '0;
        redir_depth_i = '0;
    endtask

    task automatic hold_on(input int k, input int d);
        logic [DEPTH_W-1:0] dd;
        dd = DEPTH_W'(d);
        hold_req_i[k] = 1'b1;
        hold_depth_i[k*DEPTH_W +: DEPTH_W] = dd;
    endtask

    task automatic redir(input logic [31:0] pc, input int d, input logic prio);
        redir_req_i   = 1'b1;
        redir_prio_i  = prio;
        redir_pc_i    = pc;
        redir_depth_i = DEPTH_W'(d);
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Reset: all stages refresh, no next-PC
        @(negedge clk); #1;
        chk("rst_flow", 64'(flow_o), 64'(fl(R, R, R, R, R)));
        chk("rst_vld", 64'(next_pc_vld_o), 64'd0);
        chk("rst_pc", 64'(next_pc_o), 64'd0);

        @(negedge clk); rst = 1'b0; idle(); #1;
        chk("idle_flow", 64'(flow_o), 64'(fl(W, W, W, W, W)));
        chk("idle_vld", 64'(next_pc_vld_o), 64'd0);
        chk("idle_tmo", 64'(hold_timeout_o), 64'd0);

        // Single source 3 hold, depth 4
        @(negedge clk); idle(); hold_on(3, 4); #1;
        chk("h3d4_flow", 64'(flow_o), 64'(fl(S, S, S, S, R)));
        chk("h3d4_vld", 64'(next_pc_vld_o), 64'd0);

        // Sources 1 (d=2) and 5 (d=5): source 1 wins
        @(negedge clk); idle(); hold_on(1, 2); hold_on(5, 5); #1;
        chk("h1h5_flow", 64'(flow_o), 64'(fl(S, S, R, W, W)));

        // Depth 7 saturates to STAGES: every stage stops
        @(negedge clk); idle(); hold_on(0, 7); #1;
        chk("hsat_flow", 64'(flow_o), 64'(fl(S, S, S, S, S)));

        @(negedge clk); idle(); #1;

        // Redirects under hold are captured; the first one wins
        @(negedge clk); idle(); hold_on(0, 5); #1;
        chk("pend_a_flow", 64'(flow_o), 64'(fl(S, S, S, S, S)));
        @(negedge clk); idle(); hold_on(0, 5); redir(32'h80, 2, 1'b0); #1;
        chk("pend_b_vld", 64'(next_pc_vld_o), 64'd0);
        @(negedge clk); idle(); hold_on(0, 5); redir(32'h90, 3, 1'b0); #1;
        chk("pend_c_vld", 64'(next_pc_vld_o), 64'd0);
        chk("pend_c_flow", 64'(flow_o), 64'(fl(S, S, S, S, S)));
        @(negedge clk); idle(); #1;
        chk("pend_d_vld", 64'(next_pc_vld_o), 64'd1);
        chk("pend_d_pc", 64'(next_pc_o), 64'h80);
        chk("pend_d_flow", 64'(flow_o), 64'(fl(W, R, R, W, W)));
        @(negedge clk); idle(); #1;
        chk("pend_e_vld", 64'(next_pc_vld_o), 64'd0);
        chk("pend_e_flow", 64'(flow_o), 64'(fl(W, W, W, W, W)));

        // Zero-latency redirect, depth 0 reads as 1
        @(negedge clk); idle(); redir(32'h44, 0, 1'b0); #1;
        chk("r_d0_vld", 64'(next_pc_vld_o), 64'd1);
        chk("r_d0_pc", 64'(next_pc_o), 64'h44);
        chk("r_d0_flow", 64'(flow_o), 64'(fl(W, R, W, W, W)));

        // Depth 7 saturates to STAGES-1
        @(negedge clk); idle(); redir(32'h48, 7, 1'b0); #1;
        chk("r_d7_flow", 64'(flow_o), 64'(fl(W, R, R, R, R)));

        // Pending redirect beats a live one in the same cycle
        @(negedge clk); idle(); hold_on(0, 5); redir(32'hA0, 1, 1'b0); #1;
        @(negedge clk); idle(); redir(32'hB0, 3, 1'b0); #1;
        chk("pl_pc", 64'(next_pc_o), 64'hA0);
        chk("pl_flow", 64'(flow_o), 64'(fl(W, R, W, W, W)));
        @(negedge clk); idle(); #1;
        chk("pl_after_vld", 64'(next_pc_vld_o), 64'd0);

        // Priority redirect overrides hold and drops the pending one
        @(negedge clk); idle(); hold_on(2, 3); redir(32'h50, 2, 1'b0); #1;
        chk("pr_hold_flow", 64'(flow_o), 64'(fl(S, S, S, R, W)));
        @(negedge clk); idle(); hold_on(2, 3); redir(32'h1000, 1, 1'b1); #1;
        chk("pr_flow", 64'(flow_o), 64'(fl(W, R, R, R, R)));
        chk("pr_vld", 64'(next_pc_vld_o), 64'd1);
        chk("pr_pc", 64'(next_pc_o), 64'h1000);
        @(negedge clk); idle(); #1;
        chk("pr_after_vld", 64'(next_pc_vld_o), 64'd0);

        // Watchdog: six held cycles, timeout visible in the sixth
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); idle(); hold_on(4, 1); #1;
            chk($sformatf("wdt_c%0d", i), 64'(hold_timeout_o), (i == 6) ? 64'd1 : 64'd0);
        end
        @(negedge clk); idle(); #1;
        chk("wdt_drop1", 64'(hold_timeout_o), 64'd1);
        @(negedge clk); idle(); #1;
        chk("wdt_drop2", 64'(hold_timeout_o), 64'd0);

        // Reset mid-hold with a pending redirect and an expired watchdog
        @(negedge clk); idle(); hold_on(0, 5); redir(32'h60, 2, 1'b0); #1;
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk); idle(); hold_on(0, 5); #1;
        end
        chk("mid_tmo", 64'(hold_timeout_o), 64'd1);
        @(negedge clk); rst = 1'b1; #1;
        chk("mid_rst_flow", 64'(flow_o), 64'(fl(R, R, R, R, R)));
        chk("mid_rst_vld", 64'(next_pc_vld_o), 64'd0);
        chk("mid_rst_pc", 64'(next_pc_o), 64'd0);
        @(negedge clk); rst = 1'b0; idle(); #1;
        chk("post_vld", 64'(next_pc_vld_o), 64'd0);
        chk("post_flow", 64'(flow_o), 64'(fl(W, W, W, W, W)));
        chk("post_tmo", 64'(hold_timeout_o), 64'd0);
        chk("post_perf_hold", 64'(perf_hold_cnt_o), 64'd0);
        chk("post_perf_redir", 64'(perf_redir_cnt_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
